slot_alloc_ctrl: RTL and testbench
==================================

Name: slot_alloc_ctrl

Overview:
- Allocation controller for a pool of NUM_SLOTS shared resource slots, tracked by a used-bitmap.
- Serves one requester with a req/grant handshake and returns the lowest-numbered free slot.
- The lowest-free-slot search is a multi-cycle scan of CHUNK bits per cycle, from chunk 0 upward.
- A separate free port returns slots to the pool. The block sits between slot consumers and the tag/slot-indexed datapath.

Parameters:
- NUM_SLOTS, 32, number of slots; must be a multiple of CHUNK.
- CHUNK, 8, bitmap bits examined per scan cycle.
- IDW, 5, slot index width; equals clog2(NUM_SLOTS).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- alloc_req  input  1  allocation request; level, held until alloc_gnt or alloc_fail.
- alloc_gnt  output  1  one-cycle pulse; alloc_id valid in the same cycle.
- alloc_id  output  IDW  index of the granted slot.
- alloc_fail  output  1  one-cycle pulse; pool was empty.
- free_vld  input  1  release the slot given by free_id this cycle.
- free_id  input  IDW  slot index to release.
- busy  output  1  high whenever the FSM is not in IDLE.
- used_map  output  NUM_SLOTS  registered bitmap; bit i = 1 means slot i is allocated.
- free_count  output  IDW+1  number of free slots, 0..NUM_SLOTS.

Behaviour:
- Reset (async on rst_n low, any state, including mid-scan):
  - State = IDLE, chunk pointer = 0, used_map = 0, free_count = NUM_SLOTS.
  - alloc_gnt = 0, alloc_fail = 0, alloc_id = 0, busy = 0.
  - Any in-progress scan is abandoned with no grant.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - alloc_req=1 with free_count=0 -> RESP with fail flag set.
  - alloc_req=1 with free_count>0 -> SCAN with chunk pointer = 0.
  - alloc_req=0 -> stay in IDLE.
- SCAN: examine used_map[ptr*CHUNK +: CHUNK] (registered value).
  - If any bit is 0: select the lowest zero offset o, register alloc_id = ptr*CHUNK+o, set used_map[alloc_id] at the same edge, go to RESP with the grant flag.
  - Else if ptr is the last chunk: go to RESP with fail flag. Reachable only if frees/allocs raced the scan; the count is not trusted mid-scan.
  - Else: ptr+1, stay in SCAN.
- RESP:
  - Exactly one of alloc_gnt / alloc_fail is driven high for this one cycle.
  - Always returns to IDLE. alloc_req is ignored in RESP and SCAN.
- Latency, with the request accepted in cycle 0:
  - A slot found in chunk k gives alloc_gnt in cycle k+2.
  - An empty pool gives alloc_fail in cycle 1.
  - Back-to-back requests are accepted at most every k+3 cycles.
- alloc_id holds its value until the next grant.
- Free:
  - On a clock edge with free_vld=1, free_id < NUM_SLOTS and used_map[free_id]=1: clear the bit and increment free_count.
  - Free of an already-clear slot or of an out-of-range id: no effect.
- Simultaneous events:
  - Grant and an effective free on the same edge: free_count net change is 0.
  - Free of the slot being granted on the same edge: that bit was 0, so the free is a no-op and the set wins.
  - A free landing in an already-scanned chunk is not seen by the current scan.
- Arithmetic: free_count is never below 0 or above NUM_SLOTS. Slot selection is a priority encoder on the inverted chunk, with the lowest index winning.

Test Plan:
- Reset, then alloc_req held for 9 sequential requests -> ids 0..7 each granted in cycle 2; id 8 granted in cycle 3; free_count = 23.
- Allocate all 32 slots, then one more request -> alloc_fail in cycle 1, no alloc_gnt, used_map = 0xFFFFFFFF, free_count = 0.
- From full, free_vld with free_id=13 -> free_count = 1; the next request gives alloc_gnt with alloc_id=13 in cycle 3 and used_map = 0xFFFFFFFF.
- From full, free slots 8, 9, 10 and 12 to give used_map = 0xFFFFE8FF -> a request yields alloc_id=8 in cycle 3; freeing slot 8 twice in a row changes free_count only once.
- Slots 0..15 used; request issued; during scan cycle 1, free slot 3 -> grant id 16 in cycle 4; slot 3 remains free; free_count stays consistent (net 0 on the grant edge).
- Assert rst_n low in SCAN cycle 2 of a request -> no alloc_gnt or alloc_fail pulse; all outputs at reset values; a fresh request after reset gets id 0.

Source files
------------

// File: rtl/slot_alloc_ctrl.sv
// slot_alloc_ctrl: allocation controller for a pool of NUM_SLOTS slots.
// A requester raises alloc_req and gets the lowest-numbered free slot. The
// slot is found by scanning the used bitmap CHUNK bits per cycle, starting at
// chunk 0. A separate free port returns slots to the pool.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   alloc_req    level request, held until alloc_gnt or alloc_fail
//   alloc_gnt    one-cycle grant pulse; alloc_id valid in the same cycle
//   alloc_id     granted slot index; held until the next grant
//   alloc_fail   one-cycle pulse when no slot could be allocated
//   free_vld     release free_id on this clock edge
//   free_id      slot index to release
//   busy         high whenever the FSM is not idle
//   used_map     bit i set means slot i is allocated
//   free_count   number of free slots, 0..NUM_SLOTS
module slot_alloc_ctrl #(
  parameter int unsigned NUM_SLOTS = 32,
  parameter int unsigned CHUNK     = 8,
  parameter int unsigned IDW       = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [IDW-1:0]       alloc_id,
  output logic                 alloc_fail,
  input  logic                 free_vld,
  input  logic [IDW-1:0]       free_id,
  output logic                 busy,
  output logic [NUM_SLOTS-1:0] used_map,
  output logic [IDW:0]         free_count
);

  localparam int unsigned NUM_CHUNKS = NUM_SLOTS / CHUNK;
  localparam int unsigned PTRW       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned OFFW       = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam int unsigned CNTW       = IDW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PTRW-1:0]        ptr_q, ptr_d;
  logic                   gnt_d, fail_d, busy_d;
  logic [IDW-1:0]         id_d;
  logic [NUM_SLOTS-1:0]   used_d;
  logic [CNTW-1:0]        count_d;
  logic                   grant_set;

  logic [CHUNK-1:0]       chunk_bits;
  logic                   scan_hit;
  logic [OFFW-1:0]        scan_off;
  logic [IDW-1:0]         scan_id;
  logic                   last_chunk;
  logic                   free_hit;

  // Select the chunk addressed by the scan pointer from the registered map.
  always_comb begin
    chunk_bits = '0;
    for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
      if (ptr_q == PTRW'(i)) chunk_bits = used_map[i*CHUNK +: CHUNK];
    end
  end

  // Priority encoder on the inverted chunk: lowest zero bit wins.
  always_comb begin
    scan_hit = 1'b0;
    scan_off = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (!chunk_bits[i]) begin
        scan_hit = 1'b1;
        scan_off = OFFW'(i);
      end
    end
  end

  assign scan_id    = IDW'(32'(ptr_q) * CHUNK + 32'(scan_off));
  assign last_chunk = (ptr_q == PTRW'(NUM_CHUNKS - 1));

  // A free only counts for an in-range slot that is currently allocated.
  assign free_hit = free_vld
                    && ({1'b0, free_id} < CNTW'(NUM_SLOTS))
                    && used_map[free_id];

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = 1'b0;
    fail_d    = 1'b0;
    id_d      = alloc_id;
    grant_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (alloc_req) begin
          if (free_count == '0) begin
            state_d = RESP;
            fail_d  = 1'b1;
          end else begin
            state_d = SCAN;
            ptr_d   = '0;
          end
        end
      end
      SCAN: begin
        if (scan_hit) begin
          id_d      = scan_id;
          grant_set = 1'b1;
          gnt_d     = 1'b1;
          state_d   = RESP;
        end else if (last_chunk) begin
          // Only reachable if the map changed under the scan.
          fail_d  = 1'b1;
          state_d = RESP;
        end else begin
          ptr_d = ptr_q + PTRW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Free clears first; a grant of the same slot cannot coincide with an
    // effective free because that bit is zero, so the set wins.
    used_d = used_map;
    if (free_hit) used_d[free_id] = 1'b0;
    if (grant_set) used_d[scan_id] = 1'b1;

    count_d = free_count + CNTW'(free_hit) - CNTW'(grant_set);
    busy_d  = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      alloc_gnt  <= 1'b0;
      alloc_fail <= 1'b0;
      alloc_id   <= '0;
      busy       <= 1'b0;
      used_map   <= '0;
      free_count <= CNTW'(NUM_SLOTS);
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      alloc_gnt  <= gnt_d;
      alloc_fail <= fail_d;
      alloc_id   <= id_d;
      busy       <= busy_d;
      used_map   <= used_d;
      free_count <= count_d;
    end
  end

endmodule

// File: tb/tb_slot_alloc_ctrl.sv
// Directed self-checking bench for slot_alloc_ctrl (32 slots, chunk 8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_slot_alloc_ctrl;

  logic        clk;
  logic        rst_n;
  logic        alloc_req;
  logic        alloc_gnt;
  logic [4:0]  alloc_id;
  logic        alloc_fail;
  logic        free_vld;
  logic [4:0]  free_id;
  logic        busy;
  logic [31:0] used_map;
  logic [5:0]  free_count;

  int checks = 0;
  int errors = 0;

  slot_alloc_ctrl #(.NUM_SLOTS(32), .CHUNK(8), .IDW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_id   (alloc_id),
    .alloc_fail (alloc_fail),
    .free_vld   (free_vld),
    .free_id    (free_id),
    .busy       (busy),
    .used_map   (used_map),
    .free_count (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise a request in the current (idle) cycle = cycle 0 and wait for the
  // response. cyc is the cycle the pulse was seen in (0 = never seen).
  // After the pulse one more cycle is spent so the FSM is idle on return;
  // tail reports whether a pulse was still high in that cycle.
  task automatic do_alloc(output logic g, output logic f, output logic [4:0] id,
                          output int cyc, output logic tail);
    g = 1'b0; f = 1'b0; id = '0; cyc = 0; tail = 1'b0;
    alloc_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (alloc_gnt || alloc_fail) begin
        g = alloc_gnt; f = alloc_fail; id = alloc_id; cyc = c;
        break;
      end
    end
    alloc_req = 1'b0;
    @(negedge clk);
    tail = alloc_gnt | alloc_fail;
  endtask

  task automatic do_free(input logic [4:0] id);
    free_vld = 1'b1;
    free_id  = id;
    @(negedge clk);
    free_vld = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    alloc_req = 1'b0;
    free_vld = 1'b0;
    free_id = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (alloc_gnt !== 1'b0 || alloc_fail !== 1'b0 || busy !== 1'b0 || alloc_id !== 5'd0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt=%b fail=%b busy=%b id=%0d, want 0 0 0 0",
               alloc_gnt, alloc_fail, busy, alloc_id);
    end
    checks++;
    if (used_map !== 32'h0 || free_count !== 6'd32) begin
      errors++;
      $display("FAIL reset_pool: used_map=%h free_count=%0d, want 00000000 32",
               used_map, free_count);
    end
  endtask

  // Nine requests: ids 0..7 from chunk 0 in cycle 2, id 8 from chunk 1 in cycle 3.
  task automatic test_sequential();
    logic g, f, tail; logic [4:0] id; int cyc;
    for (int i = 0; i < 9; i++) begin
      do_alloc(g, f, id, cyc, tail);
      checks++;
      if (g !== 1'b1 || f !== 1'b0 || id !== 5'(i) || cyc != ((i < 8) ? 2 : 3) || tail !== 1'b0) begin
        errors++;
        $display("FAIL seq_alloc_%0d: gnt=%b fail=%b id=%0d cyc=%0d tail=%b, want 1 0 %0d %0d 0",
                 i, g, f, id, cyc, tail, i, (i < 8) ? 2 : 3);
      end
    end
    checks++;
    if (free_count !== 6'd23 || used_map !== 32'h0000_01FF) begin
      errors++;
      $display("FAIL seq_pool: free_count=%0d used_map=%h, want 23 000001ff", free_count, used_map);
    end
  endtask

  // Fill slots 9..31, then one more request must fail in cycle 1.
  task automatic test_full();
    logic g, f, tail; logic [4:0] id; int cyc;
    for (int i = 9; i < 32; i++) begin
      do_alloc(g, f, id, cyc, tail);
      checks++;
      if (g !== 1'b1 || id !== 5'(i) || cyc != (i / 8 + 2)) begin
        errors++;
        $display("FAIL fill_%0d: gnt=%b id=%0d cyc=%0d, want 1 %0d %0d", i, g, id, cyc, i, i / 8 + 2);
      end
    end
    do_alloc(g, f, id, cyc, tail);
    checks++;
    if (f !== 1'b1 || g !== 1'b0 || cyc != 1 || tail !== 1'b0) begin
      errors++;
      $display("FAIL full_fail: fail=%b gnt=%b cyc=%0d tail=%b, want 1 0 1 0", f, g, cyc, tail);
    end
    checks++;
    if (used_map !== 32'hFFFF_FFFF || free_count !== 6'd0) begin
      errors++;
      $display("FAIL full_pool: used_map=%h free_count=%0d, want ffffffff 0", used_map, free_count);
    end
  endtask

  task automatic test_free_reuse();
    logic g, f, tail; logic [4:0] id; int cyc;
    do_free(5'd13);
    checks++;
    if (free_count !== 6'd1 || used_map !== 32'hFFFF_DFFF) begin
      errors++;
      $display("FAIL free13: free_count=%0d used_map=%h, want 1 ffffdfff", free_count, used_map);
    end
    do_alloc(g, f, id, cyc, tail);
    checks++;
    if (g !== 1'b1 || id !== 5'd13 || cyc != 3) begin
      errors++;
      $display("FAIL realloc13: gnt=%b id=%0d cyc=%0d, want 1 13 3", g, id, cyc);
    end
    checks++;
    if (used_map !== 32'hFFFF_FFFF || free_count !== 6'd0) begin
      errors++;
      $display("FAIL realloc13_pool: used_map=%h free_count=%0d, want ffffffff 0", used_map, free_count);
    end
  endtask

  task automatic test_multi_free();
    logic g, f, tail; logic [4:0] id; int cyc;
    do_free(5'd8);
    do_free(5'd9);
    do_free(5'd10);
    do_free(5'd12);
    checks++;
    if (used_map !== 32'hFFFF_E8FF || free_count !== 6'd4) begin
      errors++;
      $display("FAIL multi_free: used_map=%h free_count=%0d, want ffffe8ff 4", used_map, free_count);
    end
    do_alloc(g, f, id, cyc, tail);
    checks++;
    if (g !== 1'b1 || id !== 5'd8 || cyc != 3 || free_count !== 6'd3) begin
      errors++;
      $display("FAIL multi_alloc: gnt=%b id=%0d cyc=%0d free_count=%0d, want 1 8 3 3",
               g, id, cyc, free_count);
    end
    // Two consecutive frees of slot 8: only the first one counts.
    free_vld = 1'b1;
    free_id  = 5'd8;
    @(negedge clk);
    @(negedge clk);
    free_vld = 1'b0;
    checks++;
    if (free_count !== 6'd4 || used_map !== 32'hFFFF_E8FF) begin
      errors++;
      $display("FAIL double_free: free_count=%0d used_map=%h, want 4 ffffe8ff", free_count, used_map);
    end
    do_free(5'd9);
    checks++;
    if (free_count !== 6'd4 || used_map !== 32'hFFFF_E8FF) begin
      errors++;
      $display("FAIL free_clear_slot: free_count=%0d used_map=%h, want 4 ffffe8ff", free_count, used_map);
    end
  endtask

  // Slots 0..15 used. Free slot 3 during scan cycle 1 (chunk 0 already
  // examined) and slot 5 on the grant edge; grant must be 16 in cycle 4.
  task automatic test_race();
    logic g, f, tail; logic [4:0] id; int cyc;
    apply_reset();
    for (int i = 0; i < 16; i++) do_alloc(g, f, id, cyc, tail);
    checks++;
    if (used_map !== 32'h0000_FFFF || free_count !== 6'd16) begin
      errors++;
      $display("FAIL race_setup: used_map=%h free_count=%0d, want 0000ffff 16", used_map, free_count);
    end
    alloc_req = 1'b1;              // cycle 0
    @(negedge clk);                // cycle 1: scanning chunk 0
    free_vld = 1'b1;
    free_id  = 5'd3;
    @(negedge clk);                // cycle 2: scanning chunk 1
    free_vld = 1'b0;
    checks++;
    if (free_count !== 6'd17 || busy !== 1'b1 || alloc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL race_midscan: free_count=%0d busy=%b gnt=%b, want 17 1 0", free_count, busy, alloc_gnt);
    end
    @(negedge clk);                // cycle 3: scanning chunk 2, grant edge next
    free_vld = 1'b1;
    free_id  = 5'd5;
    @(negedge clk);                // cycle 4: response
    free_vld  = 1'b0;
    alloc_req = 1'b0;
    checks++;
    if (alloc_gnt !== 1'b1 || alloc_id !== 5'd16 || alloc_fail !== 1'b0) begin
      errors++;
      $display("FAIL race_grant: gnt=%b id=%0d fail=%b, want 1 16 0", alloc_gnt, alloc_id, alloc_fail);
    end
    checks++;
    if (free_count !== 6'd17 || used_map !== 32'h0001_FFD7) begin
      errors++;
      $display("FAIL race_pool: free_count=%0d used_map=%h, want 17 0001ffd7", free_count, used_map);
    end
    @(negedge clk);
  endtask

  // Free of the slot being granted on the grant edge is a no-op.
  task automatic test_free_granted();
    alloc_req = 1'b1;              // cycle 0
    @(negedge clk);                // cycle 1: chunk 0 scan finds slot 3
    free_vld = 1'b1;
    free_id  = 5'd3;
    @(negedge clk);                // cycle 2: response
    free_vld  = 1'b0;
    alloc_req = 1'b0;
    checks++;
    if (alloc_gnt !== 1'b1 || alloc_id !== 5'd3) begin
      errors++;
      $display("FAIL free_granted_gnt: gnt=%b id=%0d, want 1 3", alloc_gnt, alloc_id);
    end
    checks++;
    if (used_map !== 32'h0001_FFDF || free_count !== 6'd16) begin
      errors++;
      $display("FAIL free_granted_pool: used_map=%h free_count=%0d, want 0001ffdf 16", used_map, free_count);
    end
    @(negedge clk);
  endtask

  // Reset asserted while scanning chunk 1: no response pulse, clean restart.
  task automatic test_reset_mid_scan();
    logic g, f, tail; logic [4:0] id; int cyc;
    logic pulse_seen;
    do_alloc(g, f, id, cyc, tail);
    checks++;
    if (g !== 1'b1 || id !== 5'd5 || cyc != 2) begin
      errors++;
      $display("FAIL pre_reset_alloc: gnt=%b id=%0d cyc=%0d, want 1 5 2", g, id, cyc);
    end
    alloc_req = 1'b1;              // cycle 0, lowest free slot is 17
    @(negedge clk);                // cycle 1
    @(negedge clk);                // cycle 2
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || alloc_gnt !== 1'b0 || alloc_fail !== 1'b0 || alloc_id !== 5'd0
        || used_map !== 32'h0 || free_count !== 6'd32) begin
      errors++;
      $display("FAIL async_reset: busy=%b gnt=%b fail=%b id=%0d used_map=%h free_count=%0d, want 0 0 0 0 00000000 32",
               busy, alloc_gnt, alloc_fail, alloc_id, used_map, free_count);
    end
    pulse_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      pulse_seen |= alloc_gnt | alloc_fail;
    end
    alloc_req = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      pulse_seen |= alloc_gnt | alloc_fail;
    end
    checks++;
    if (pulse_seen !== 1'b0 || busy !== 1'b0 || used_map !== 32'h0 || free_count !== 6'd32) begin
      errors++;
      $display("FAIL post_reset: pulse=%b busy=%b used_map=%h free_count=%0d, want 0 0 00000000 32",
               pulse_seen, busy, used_map, free_count);
    end
    do_alloc(g, f, id, cyc, tail);
    checks++;
    if (g !== 1'b1 || id !== 5'd0 || cyc != 2 || used_map !== 32'h1) begin
      errors++;
      $display("FAIL fresh_alloc: gnt=%b id=%0d cyc=%0d used_map=%h, want 1 0 2 00000001",
               g, id, cyc, used_map);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    alloc_req = 1'b0;
    free_vld  = 1'b0;
    free_id   = '0;
    test_reset();
    test_sequential();
    test_full();
    test_free_reuse();
    test_multi_free();
    test_race();
    test_free_granted();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
